// File: rtl/ps2_dev_port.sv
// PS2 device-side endpoint: generates the link clock, sends held bytes to the host and
// clocks in/ACKs host commands. A single holding register gives tx backpressure via tx_ready_o.
`timescale 1ns/1ps
module ps2_dev_port #(
   parameter int CLK_HALF_US = 40,
   parameter int IDLE_US     = 50,
   parameter int SENSE_US    = 5
) (
   input  logic       clk6x,
   input  logic       reset,
   input  logic       ck1us,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       tx_abort_o,
   output logic       tx_done_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       rx_err_o,
   output logic       busy_o,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic       PS2_CLKDR,
   output logic       PS2_DATADR
);

   typedef enum logic [2:0] {
      S_IDLE, S_TX_HI, S_TX_LO, S_RX_HI, S_RX_LO, S_ACK_HI, S_ACK_LO
   } state_t;

   state_t      r_state;
   logic [1:0]  r_clk_sy, r_dat_sy;
   logic [7:0]  r_tmr;
   logic [3:0]  r_bit;
   logic [7:0]  r_hold;
   logic        r_full;
   logic [7:0]  r_rx_sh;
   logic        r_rx_par, r_rx_stop;
   logic [7:0]  r_rx_data;
   logic        r_rx_err, r_rx_vld;
   logic        r_done, r_abort;
   logic        r_clkdr, r_datadr;

   logic w_clk, w_dat, w_half_end;

   assign w_clk      = r_clk_sy[1];
   assign w_dat      = r_dat_sy[1];
   assign w_half_end = ck1us && (r_tmr == 8'(CLK_HALF_US - 1));

   assign tx_ready_o = ~r_full;
   assign tx_abort_o = r_abort;
   assign tx_done_o  = r_done;
   assign rx_data_o  = r_rx_data;
   assign rx_valid_o = r_rx_vld;
   assign rx_err_o   = r_rx_err;
   assign busy_o     = (r_state != S_IDLE);
   assign PS2_CLKDR  = r_clkdr;
   assign PS2_DATADR = r_datadr;

   // Frame bit index 0 = start, 1..8 = data LSB first, 9 = odd parity, 10 = stop.
   function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
      logic b;
      case (idx)
         4'd0:    b = 1'b0;
         4'd9:    b = ~^d;
         4'd10:   b = 1'b1;
         default: b = d[3'(idx - 4'd1)];
      endcase
      return b;
   endfunction

   always_ff @(posedge clk6x or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_clk_sy  <= 2'b00;
         r_dat_sy  <= 2'b00;
         r_tmr     <= 8'd0;
         r_bit     <= 4'd0;
         r_hold    <= 8'd0;
         r_full    <= 1'b0;
         r_rx_sh   <= 8'd0;
         r_rx_par  <= 1'b0;
         r_rx_stop <= 1'b0;
         r_rx_data <= 8'd0;
         r_rx_err  <= 1'b0;
         r_rx_vld  <= 1'b0;
         r_done    <= 1'b0;
         r_abort   <= 1'b0;
         r_clkdr   <= 1'b0;
         r_datadr  <= 1'b0;
      end else begin
         r_clk_sy <= {r_clk_sy[0], PS2_CLK};
         r_dat_sy <= {r_dat_sy[0], PS2_DATA};
         r_done   <= 1'b0;
         r_abort  <= 1'b0;
         r_rx_vld <= 1'b0;
         if (ck1us) r_tmr <= r_tmr + 8'd1;
         if (tx_valid_i && !r_full) begin
            r_hold <= tx_data_i;
            r_full <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               r_clkdr  <= 1'b0;
               r_datadr <= 1'b0;
               if (w_clk && !w_dat) begin
                  r_state <= S_RX_HI;
                  r_bit   <= 4'd0;
                  r_tmr   <= 8'd0;
               end else if (!(w_clk && w_dat)) begin
                  r_tmr <= 8'd0;
               end else if (r_tmr == 8'(IDLE_US)) begin
                  // Idle window saturates so a byte loaded after a long quiet spell goes at once.
                  r_tmr <= r_tmr;
                  if (r_full) begin
                     r_state  <= S_TX_HI;
                     r_bit    <= 4'd0;
                     r_tmr    <= 8'd0;
                     r_datadr <= ~frame_bit(r_hold, 4'd0);
                  end
               end
            end
            S_TX_HI: begin
               if (r_tmr == 8'(SENSE_US) && !w_clk) begin
                  r_state  <= S_IDLE;
                  r_tmr    <= 8'd0;
                  r_clkdr  <= 1'b0;
                  r_datadr <= 1'b0;
                  r_abort  <= 1'b1;
               end else if (w_half_end) begin
                  r_state <= S_TX_LO;
                  r_tmr   <= 8'd0;
                  r_clkdr <= 1'b1;
               end
            end
            S_TX_LO: begin
               if (w_half_end) begin
                  r_tmr   <= 8'd0;
                  r_clkdr <= 1'b0;
                  if (r_bit == 4'd10) begin
                     r_state  <= S_IDLE;
                     r_datadr <= 1'b0;
                     r_done   <= 1'b1;
                     r_full   <= 1'b0;
                  end else begin
                     r_state  <= S_TX_HI;
                     r_bit    <= r_bit + 4'd1;
                     r_datadr <= ~frame_bit(r_hold, r_bit + 4'd1);
                  end
               end
            end
            S_RX_HI: begin
               if (w_half_end) begin
                  r_tmr <= 8'd0;
                  if (!w_clk) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_RX_LO;
                     r_clkdr <= 1'b1;
                     if (r_bit < 4'd8)       r_rx_sh   <= {w_dat, r_rx_sh[7:1]};
                     else if (r_bit == 4'd8) r_rx_par  <= w_dat;
                     else                    r_rx_stop <= w_dat;
                  end
               end
            end
            S_RX_LO: begin
               if (w_half_end) begin
                  r_tmr   <= 8'd0;
                  r_clkdr <= 1'b0;
                  if (r_bit != 4'd9) begin
                     r_state <= S_RX_HI;
                     r_bit   <= r_bit + 4'd1;
                  end else if (r_rx_stop) begin
                     r_state  <= S_ACK_HI;
                     r_datadr <= 1'b1;
                  end else begin
                     r_state   <= S_IDLE;
                     r_rx_vld  <= 1'b1;
                     r_rx_data <= r_rx_sh;
                     r_rx_err  <= 1'b1;
                  end
               end
            end
            S_ACK_HI: begin
               if (w_half_end) begin
                  r_state <= S_ACK_LO;
                  r_tmr   <= 8'd0;
                  r_clkdr <= 1'b1;
               end
            end
            default: begin
               if (w_half_end) begin
                  r_state   <= S_IDLE;
                  r_tmr     <= 8'd0;
                  r_clkdr   <= 1'b0;
                  r_datadr  <= 1'b0;
                  r_rx_vld  <= 1'b1;
                  r_rx_data <= r_rx_sh;
                  r_rx_err  <= ~(^{r_rx_sh, r_rx_par});
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_dev_port.sv
// Bench for ps2_dev_port: open-drain host model, frame model from the PS2 framing rules.
`timescale 1ns/1ps
module tb_ps2_dev_port;
   localparam int TCLK = 10;
   localparam int US   = 4 * TCLK;

   logic       clk6x = 1'b0;
   logic       reset = 1'b1;
   logic       ck1us = 1'b0;
   logic [7:0] tx_data_i = 8'd0;
   logic       tx_valid_i = 1'b0;
   logic       tx_ready_o, tx_abort_o, tx_done_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o, rx_err_o, busy_o;
   logic       PS2_CLKDR, PS2_DATADR;
   logic       host_clk_low = 1'b0, host_dat_low = 1'b0;
   logic       ps2_clk_pin, ps2_dat_pin;

   assign ps2_clk_pin = ~(PS2_CLKDR | host_clk_low);
   assign ps2_dat_pin = ~(PS2_DATADR | host_dat_low);

   ps2_dev_port dut (
      .clk6x(clk6x), .reset(reset), .ck1us(ck1us),
      .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .tx_abort_o(tx_abort_o), .tx_done_o(tx_done_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_err_o(rx_err_o),
      .busy_o(busy_o), .PS2_CLK(ps2_clk_pin), .PS2_DATA(ps2_dat_pin),
      .PS2_CLKDR(PS2_CLKDR), .PS2_DATADR(PS2_DATADR)
   );

   int errors = 0, checks = 0;
   int n_done = 0, n_abort = 0, n_rx = 0;
   logic [7:0] last_rx = 8'd0;
   logic       last_err = 1'b0;
   logic       q_bits[$];
   time        q_t[$];

   initial forever #(TCLK/2) clk6x = ~clk6x;

   initial begin
      int c = 0;
      forever begin
         @(negedge clk6x);
         c = (c + 1) % 4;
         ck1us = (c == 0);
      end
   end

   always @(negedge clk6x) begin
      if (tx_done_o)  n_done  <= n_done + 1;
      if (tx_abort_o) n_abort <= n_abort + 1;
      if (rx_valid_o) begin
         n_rx     <= n_rx + 1;
         last_rx  <= rx_data_o;
         last_err <= rx_err_o;
      end
   end

   // Host samples DATA on every falling edge of the CLK pin.
   always @(negedge ps2_clk_pin) begin
      q_bits.push_back(ps2_dat_pin);
      q_t.push_back($time);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] model_frame(input logic [7:0] b);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      f[9]  = ($countones(b) % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   function automatic int cnt(input int which);
      if (which == 0) return n_done;
      if (which == 1) return n_abort;
      return n_rx;
   endfunction

   task automatic wait_evt(input string tag, input int which, input int base, input int budget);
      bit got = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk6x);
         if (cnt(which) != base) got = 1;
      end
      chk(tag, 32'(got), 32'd1);
   endtask

   task automatic wait_edge(input bit rising, input int budget, output bit ok);
      logic prev = ps2_clk_pin;
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk6x);
         if (rising ? (!prev && ps2_clk_pin) : (prev && !ps2_clk_pin)) ok = 1;
         prev = ps2_clk_pin;
      end
   endtask

   task automatic load_tx(input logic [7:0] b);
      bit got = 0;
      for (int i = 0; i < 8000 && !got; i++) begin
         @(negedge clk6x);
         if (tx_ready_o) got = 1;
      end
      chk("tx_ready_before_load", 32'(got), 32'd1);
      tx_data_i  = b;
      tx_valid_i = 1'b1;
      @(negedge clk6x);
      tx_valid_i = 1'b0;
      chk("tx_ready_drop", 32'(tx_ready_o), 32'd0);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] b);
      logic [10:0] obs = '0;
      bit per_ok = 1;
      for (int i = 0; i < q_bits.size() && i < 11; i++) obs[i] = q_bits[i];
      for (int i = 1; i < q_t.size(); i++)
         if (q_t[i] - q_t[i-1] > 81 * US || q_t[i] - q_t[i-1] < 79 * US) per_ok = 0;
      chk({tag, "_edges"}, 32'(q_bits.size()), 32'd11);
      chk({tag, "_bits"}, 32'(obs), 32'(model_frame(b)));
      chk({tag, "_period"}, 32'(per_ok), 32'd1);
   endtask

   task automatic run_tx(input string tag, input logic [7:0] b);
      int base = n_done;
      q_bits.delete(); q_t.delete();
      load_tx(b);
      wait_evt({tag, "_done"}, 0, base, 6000);
      check_frame(tag, b);
      chk({tag, "_ready_back"}, 32'(tx_ready_o), 32'd1);
   endtask

   task automatic host_send(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic [9:0] bits;
      bit ok, all_ok = 1, dr_ok = 1, noack_ok = 1, got = 0;
      int base = n_rx;
      bits[7:0] = b;
      bits[8]   = ($countones(b) % 2 == 0) ^ bad_par;
      bits[9]   = ~bad_stop;
      host_dat_low = 1'b1;
      #(10 * US);
      host_dat_low = ~bits[0];
      for (int i = 1; i <= 10; i++) begin
         wait_edge(1'b0, 600, ok);
         all_ok &= ok;
         if (PS2_DATADR) dr_ok = 0;
         host_dat_low = (i <= 9) ? ~bits[i] : 1'b0;
      end
      chk({tag, "_clocks"}, 32'(all_ok), 32'd1);
      chk({tag, "_no_early_drive"}, 32'(dr_ok), 32'd1);
      if (!bad_stop) begin
         wait_edge(1'b0, 600, ok);
         chk({tag, "_ack_clock"}, 32'(ok), 32'd1);
         chk({tag, "_ack_datadr"}, 32'(PS2_DATADR), 32'd1);
         chk({tag, "_ack_pin"}, 32'(ps2_dat_pin), 32'd0);
      end
      for (int i = 0; i < 800 && !got; i++) begin
         @(negedge clk6x);
         if (PS2_DATADR) noack_ok = 0;
         if (n_rx != base) got = 1;
      end
      chk({tag, "_rx_valid"}, 32'(got), 32'd1);
      chk({tag, "_rx_data"}, 32'(last_rx), 32'(b));
      chk({tag, "_rx_err"}, 32'(last_err), 32'(bad_par | bad_stop));
      if (bad_stop) chk({tag, "_no_ack"}, 32'(noack_ok), 32'd1);
   endtask

   initial begin
      bit ok;
      int base_d, base_a;
      time t_rel;
      logic [7:0] rb;

      #(3 * TCLK + 1);
      chk("rst_ready", 32'(tx_ready_o), 32'd1);
      chk("rst_pulses", 32'({tx_abort_o, tx_done_o, rx_valid_o}), 32'd0);
      chk("rst_rx", 32'({rx_data_o, rx_err_o, busy_o}), 32'd0);
      chk("rst_lines", 32'({PS2_CLKDR, PS2_DATADR}), 32'd0);
      @(negedge clk6x);
      reset = 1'b0;
      repeat (300) @(negedge clk6x);

      // tx 0xAA and single done pulse
      base_d = n_done;
      run_tx("tx_aa", 8'hAA);
      repeat (400) @(negedge clk6x);
      chk("tx_aa_done_once", 32'(n_done - base_d), 32'd1);

      host_send("rx_ed", 8'hED, 1'b0, 1'b0);
      repeat (300) @(negedge clk6x);
      host_send("rx_55_badpar", 8'h55, 1'b1, 1'b0);
      repeat (300) @(negedge clk6x);
      host_send("rx_3a_badstop", 8'h3A, 1'b0, 1'b1);
      repeat (300) @(negedge clk6x);

      // host inhibit during bit 4, then full retransmit
      base_d = n_done; base_a = n_abort;
      q_bits.delete(); q_t.delete();
      load_tx(8'h1C);
      for (int i = 0; i < 4; i++) wait_edge(1'b0, 2000, ok);
      wait_edge(1'b1, 2000, ok);
      #(1 * US);
      host_clk_low = 1'b1;
      wait_evt("inh_abort", 1, base_a, 400);
      @(negedge clk6x);
      chk("inh_lines_released", 32'({PS2_CLKDR, PS2_DATADR}), 32'd0);
      chk("inh_byte_kept", 32'(tx_ready_o), 32'd0);
      chk("inh_no_done", 32'(n_done - base_d), 32'd0);
      repeat (400) @(negedge clk6x);
      host_clk_low = 1'b0;
      t_rel = $time;
      q_bits.delete(); q_t.delete();
      wait_evt("inh_retx_done", 0, base_d, 6000);
      check_frame("inh_retx", 8'h1C);
      chk("inh_idle_gap", 32'((q_t.size() > 0) && (q_t[0] - t_rel >= 88 * US) &&
                              (q_t[0] - t_rel <= 92 * US)), 32'd1);
      repeat (300) @(negedge clk6x);

      // tx queued while host holds RTS: rx first, then tx
      base_d = n_done;
      fork
         host_send("rts_ff", 8'hFF, 1'b0, 1'b0);
         begin
            #(3 * US);
            load_tx(8'hFA);
         end
      join
      chk("rts_tx_deferred", 32'(n_done - base_d), 32'd0);
      q_bits.delete(); q_t.delete();
      wait_evt("rts_fa_done", 0, base_d, 6000);
      check_frame("rts_fa", 8'hFA);
      repeat (300) @(negedge clk6x);

      for (int r = 0; r < 2; r++) begin
         rb = 8'($urandom);
         run_tx("rnd_tx", rb);
         repeat (200) @(negedge clk6x);
         rb = 8'($urandom);
         host_send("rnd_rx", rb, 1'($urandom_range(0, 1)), 1'b0);
         repeat (200) @(negedge clk6x);
      end

      // reset during bit 6
      base_d = n_done; base_a = n_abort;
      load_tx(8'h3C);
      for (int i = 0; i < 7; i++) wait_edge(1'b0, 2000, ok);
      chk("mid_busy", 32'(busy_o), 32'd1);
      #(2 * US);
      reset = 1'b1;
      #1;
      chk("mid_rst_lines", 32'({PS2_CLKDR, PS2_DATADR}), 32'd0);
      chk("mid_rst_ready", 32'(tx_ready_o), 32'd1);
      repeat (5) @(negedge clk6x);
      reset = 1'b0;
      repeat (1200) @(negedge clk6x);
      chk("mid_rst_no_done", 32'(n_done - base_d), 32'd0);
      chk("mid_rst_no_abort", 32'(n_abort - base_a), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
